// File: rtl/timer_bus_arbiter.sv
// rtl/timer_bus_arbiter.sv - two-master round-robin arbiter onto the TC0/TC1 timer register windows
// Optional m0_err/m1_err unmapped-access outputs are built when TIMER_BUS_ERR_EN is defined.
module timer_bus_arbiter #(
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [29:0] tc0_addr,
  output logic        tc0_we,
  output logic [31:0] tc0_din,
  input  logic [31:0] tc0_dout,
  input  logic        tc0_irq,
  output logic [29:0] tc1_addr,
  output logic        tc1_we,
  output logic [31:0] tc1_din,
  input  logic [31:0] tc1_dout,
  input  logic        tc1_irq,
  input  logic        ext_irq,
`ifdef TIMER_BUS_ERR_EN
  output logic        m0_err,
  output logic        m1_err,
`endif
  output logic [5:0]  hwint
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        last_grant, grant, we_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        any_req, pick;
  logic [31:0] off0, off1;
  logic        hit0, hit1;

  assign any_req = m0_req | m1_req;
  // On a tie the master that was not served last wins; 1 means m1.
  assign pick    = (m0_req & m1_req) ? ~last_grant : m1_req;

  // Unaligned offsets and BASE+0xC fall outside the three-word window.
  assign off0 = addr_q - TC0_BASE;
  assign off1 = addr_q - TC1_BASE;
  assign hit0 = (off0 == 32'h0) | (off0 == 32'h4) | (off0 == 32'h8);
  assign hit1 = (off1 == 32'h0) | (off1 == 32'h4) | (off1 == 32'h8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tc0_we   = 1'b0;
    tc1_we   = 1'b0;
    tc0_addr = addr_q[31:2];
    tc1_addr = addr_q[31:2];
    tc0_din  = wdata_q;
    tc1_din  = wdata_q;
    if (state == ACCESS) begin
      tc0_we = we_q & hit0;
      tc1_we = we_q & hit1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
    end else begin
      m0_ack <= (state == RESP) & ~grant;
      m1_ack <= (state == RESP) & grant;
      if (state == IDLE && any_req) begin
        grant      <= pick;
        last_grant <= pick;
        we_q       <= pick ? m1_we    : m0_we;
        addr_q     <= pick ? m1_addr  : m0_addr;
        wdata_q    <= pick ? m1_wdata : m0_wdata;
      end
      if (state == ACCESS)
        rdata_q <= hit0 ? tc0_dout : (hit1 ? tc1_dout : 32'h0);
    end
  end

`ifdef TIMER_BUS_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_err <= 1'b0;
      m1_err <= 1'b0;
    end else begin
      m0_err <= (state == RESP) & ~grant & ~(hit0 | hit1);
      m1_err <= (state == RESP) & grant & ~(hit0 | hit1);
    end
  end
`endif

  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;
  assign hwint    = {3'b000, ext_irq, tc1_irq, tc0_irq};

endmodule
